// File: rtl/sram22_arb_pkg.sv
// Shared types and constants for the sram22 port arbiter.
package sram22_arb_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int RAM_DEPTH      = 1 << DEF_ADDR_WIDTH;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram22_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps upward.
// The pointer moves one past each winner and holds on idle cycles.
module sram22_rr_arbiter
    import sram22_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDW    = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] idx;

    // Priority search starting at the pointer; first valid requester wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (en && !grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
        next_ptr = IDW'((int'(grant_id) + 1) % NUM_REQ);
    end

    // Pointer advances past the winner; unchanged when nothing is granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/sram22_port_arbiter.sv
// Shares one sram22 single-port macro between NUM_REQ requesters.
// One access per cycle, registered macro pins, read data returned two
// cycles after accept on a shared bus tagged by a one-hot rsp_valid.
// Optional build macro SRAM22_ARB_INIT_EN: after reset, zero every word
// of the macro (one address per cycle) before accepting requests.
module sram22_port_arbiter
    import sram22_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 24,
    parameter int WMASK_WIDTH = 3,
    parameter int NUM_REQ     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           init_done,
    output logic                           sram_rstb,
    output logic                           sram_ce,
    output logic                           sram_we,
    output logic [WMASK_WIDTH-1:0]         sram_wmask,
    output logic [ADDR_WIDTH-1:0]          sram_addr,
    output logic [DATA_WIDTH-1:0]          sram_din,
    input  logic [DATA_WIDTH-1:0]          sram_dout
);

    localparam int IDW = idx_width(NUM_REQ);

    state_t                 state_q, state_d;
    logic                   serve;
    logic                   grant_valid;
    logic [IDW-1:0]         grant_id;
    logic                   sel_we;
    logic [WMASK_WIDTH-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   rd_vld_q1, rd_vld_q2;
    logic [IDW-1:0]         rd_id_q1, rd_id_q2;
`ifdef SRAM22_ARB_INIT_EN
    logic [ADDR_WIDTH-1:0]  init_cnt;
`endif

    assign serve     = (state_q == ST_SERVE);
    assign init_done = serve;
    assign sram_rstb = ~rst;
    assign rsp_rdata = sram_dout;

    sram22_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (serve),
        .req         (req_valid),
        .grant       (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Mux the winning port's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_wmask = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_we    = req_we[i];
                sel_wmask = req_wmask[i*WMASK_WIDTH +: WMASK_WIDTH];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: INIT ends after the sweep (or at once); SERVE holds until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
`ifdef SRAM22_ARB_INIT_EN
                if (init_cnt == '1) begin
                    state_d = ST_SERVE;
                end
`else
                state_d = ST_SERVE;
`endif
            end
            ST_SERVE: state_d = ST_SERVE;
            default:  state_d = ST_INIT;
        endcase
    end

`ifdef SRAM22_ARB_INIT_EN
    // Sweep address counter; restarts from zero on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
        end
    end
`endif

    // Macro pin register: sweep writes, granted accesses, otherwise disabled.
    always_ff @(posedge clk) begin
        // NOTE: only the control pins are reset; address and data are
        // don't-care while ce=0, so they carry no reset.
        if (rst) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_wmask <= '0;
`ifdef SRAM22_ARB_INIT_EN
        end else if (state_q == ST_INIT) begin
            sram_ce    <= 1'b1;
            sram_we    <= 1'b1;
            sram_wmask <= '1;
            sram_addr  <= init_cnt;
            sram_din   <= '0;
`endif
        end else if (grant_valid) begin
            sram_ce    <= 1'b1;
            sram_we    <= sel_we;
            sram_wmask <= sel_we ? sel_wmask : '0;
            sram_addr  <= sel_addr;
            sram_din   <= sel_wdata;
        end else begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_wmask <= '0;
        end
    end

    // Two-stage tag pipe carrying the port id of each read to its data cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q1 <= 1'b0;
            rd_vld_q2 <= 1'b0;
        end else begin
            rd_vld_q1 <= grant_valid & ~sel_we;
            rd_vld_q2 <= rd_vld_q1;
        end
        rd_id_q1 <= grant_id;
        rd_id_q2 <= rd_id_q1;
    end

    // Decode the returning tag into the one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_vld_q2 && (rd_id_q2 == IDW'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

endmodule
